// File: rtl/multiword_add_sequencer.sv
// Word-serial adder: one BITS-wide ripple slice reused across WORDS words of A+B+ci.
// Latency: done pulses in the cycle after the WORDS-th edge following an accepted start.
// Backpressure: none; start is ignored while busy or done, and abort cancels an add in flight.
module multiword_add_sequencer #(
    parameter int BITS  = 2,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [BITS*WORDS-1:0] a_in,
    input  logic [BITS*WORDS-1:0] b_in,
    input  logic                  ci,
    output logic                  busy,
    output logic                  done,
    output logic [BITS*WORDS-1:0] sum,
    output logic                  co
);

    localparam int W  = BITS * WORDS;
    localparam int IW = $clog2(WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_co;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;

    logic [BITS-1:0]  w_a_word;
    logic [BITS-1:0]  w_b_word;
    logic [BITS-1:0]  w_slice_sum;
    logic [BITS:0]    w_c;
    logic [W-1:0]     w_sum_next;

    // Select the operand words addressed by the current word index.
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_word = r_a[k*BITS +: BITS];
                w_b_word = r_b[k*BITS +: BITS];
            end
        end
    end

    // The single shared ripple-carry slice; carry-in is the carry register.
    assign w_c[0] = r_carry;
    for (genvar g = 0; g < BITS; g++) begin : g_fa
        assign w_slice_sum[g] = w_a_word[g] ^ w_b_word[g] ^ w_c[g];
        assign w_c[g+1]       = (w_a_word[g] & w_b_word[g])
                              | (w_c[g] & (w_a_word[g] ^ w_b_word[g]));
    end

    // Merge the slice result into the addressed word of the running sum.
    always_comb begin
        w_sum_next = r_sum;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IW'(k)) begin
                w_sum_next[k*BITS +: BITS] = w_slice_sum;
            end
        end
    end

    // Sequencer FSM with registered status outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= ci;
                        r_sum   <= '0;
                        r_co    <= 1'b0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (abort) begin
                        // Cancelled: drop partial result, no done pulse.
                        r_sum   <= '0;
                        r_co    <= 1'b0;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_sum   <= w_sum_next;
                        r_carry <= w_c[BITS];
                        if (r_idx == LAST_IDX) begin
                            // Index parks at 0 so it never runs past the last word.
                            r_co    <= w_c[BITS];
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

    logic       clk;
    logic       rst_n;

    // Default configuration: BITS=2, WORDS=4
    logic       start, abort, ci, busy, done, co;
    logic [7:0] a_in, b_in, sum;

    // BITS=2, WORDS=1
    logic       s1_start, s1_abort, s1_ci, s1_busy, s1_done, s1_co;
    logic [1:0] s1_a, s1_b, s1_sum;

    // BITS=2, WORDS=2
    logic       s2_start, s2_abort, s2_ci, s2_busy, s2_done, s2_co;
    logic [3:0] s2_a, s2_b, s2_sum;

    int checks = 0;
    int errors = 0;

    multiword_add_sequencer #(.BITS(2), .WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_in(a_in), .b_in(b_in), .ci(ci),
        .busy(busy), .done(done), .sum(sum), .co(co)
    );

    multiword_add_sequencer #(.BITS(2), .WORDS(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort),
        .a_in(s1_a), .b_in(s1_b), .ci(s1_ci),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .co(s1_co)
    );

    multiword_add_sequencer #(.BITS(2), .WORDS(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .abort(s2_abort),
        .a_in(s2_a), .b_in(s2_b), .ci(s2_ci),
        .busy(s2_busy), .done(s2_done), .sum(s2_sum), .co(s2_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] es;
        logic       eco;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete addition on the default instance with timing checks.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic eco, input string tag);
        @(negedge clk);
        a_in = a; b_in = b; ci = c; start = 1'b1;
        tick();
        start = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); ci = 1'($urandom);
        check({tag, " accept busy/done"}, {busy, done}, 2'b10);
        check({tag, " accept clears result"}, {co, sum}, 9'h000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) check({tag, " adding busy/done"}, {busy, done}, 2'b10);
            else       check({tag, " done pulse busy/done"}, {busy, done}, 2'b01);
        end
        check({tag, " sum"}, sum, es);
        check({tag, " co"}, co, eco);
        tick();
        check({tag, " after done busy/done"}, {busy, done}, 2'b00);
        check({tag, " result held"}, {co, sum}, {eco, es});
    endtask

    task automatic ex1(input logic [1:0] a, input logic [1:0] b, input logic c);
        logic [2:0] e;
        e = {1'b0, a} + {1'b0, b} + {2'b00, c};
        @(negedge clk);
        s1_a = a; s1_b = b; s1_ci = c; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        check("w1 busy after accept", {s1_busy, s1_done}, 2'b10);
        tick();
        check("w1 done and result", {s1_done, s1_co, s1_sum}, {1'b1, e});
        tick();
    endtask

    task automatic ex2(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] e;
        e = {1'b0, a} + {1'b0, b} + {4'h0, c};
        @(negedge clk);
        s2_a = a; s2_b = b; s2_ci = c; s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        tick();
        check("w2 still busy", {s2_busy, s2_done}, 2'b10);
        tick();
        check("w2 done and result", {s2_done, s2_co, s2_sum}, {1'b1, e});
        tick();
    endtask

    initial begin
        int         dcount;
        logic [8:0] m;
        logic [7:0] ra, rb;
        logic       rc;

        vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[1] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
        vt[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vt[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vt[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0;
        start = 0; abort = 0; ci = 0; a_in = 8'hC3; b_in = 8'h3C;
        s1_start = 0; s1_abort = 0; s1_ci = 0; s1_a = 0; s1_b = 0;
        s2_start = 0; s2_abort = 0; s2_ci = 0; s2_a = 0; s2_b = 0;
        #1;
        check("reset outputs", {busy, done, co, sum}, 11'h000);
        check("reset w1/w2 outputs", {s1_busy, s1_done, s2_busy, s2_done}, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle after reset", {busy, done, co, sum}, 11'h000);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_add(vt[i].a, vt[i].b, vt[i].c, vt[i].es, vt[i].eco, $sformatf("vec%0d", i));
        end

        // Randomized operands against arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            m  = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            do_add(ra, rb, rc, m[7:0], m[8], "rand");
        end

        // Start held high while busy: second operands ignored
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h33; ci = 1'b1; start = 1'b1;
        tick();
        a_in = 8'h12; b_in = 8'h34; ci = 1'b0;
        repeat (3) tick();
        tick();
        check("held start done", {busy, done}, 2'b01);
        check("held start first result", {co, sum}, 9'h08E);
        tick();
        check("held start ignored in done", {busy, done, co, sum}, {2'b00, 9'h08E});
        tick();
        check("held start new accept", {busy, done, co, sum}, {2'b10, 9'h000});
        start = 1'b0;
        repeat (4) tick();
        check("held start second result", {done, co, sum}, {1'b1, 9'h046});
        tick();

        // Abort on the 2nd ADD cycle
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'hFF; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("partial word0 before abort", sum[1:0], 2'b11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort clears", {busy, done, co, sum}, 11'h000);
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) dcount++;
        end
        check("abort no done pulse", dcount, 0);
        do_add(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, "after abort");

        // Abort coinciding with final word edge
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'h01; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort wins final edge", {busy, done, co, sum}, 11'h000);
        tick();
        check("abort final no done", {busy, done}, 2'b00);

        // Abort ignored in IDLE and DONE
        do_add(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, "pre idle abort");
        abort = 1'b1;
        repeat (2) tick();
        abort = 1'b0;
        check("idle abort ignored", {busy, done, co, sum}, {2'b00, 9'h100});
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("done before abort", done, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("done abort ignored", {busy, done, co, sum}, {2'b00, 9'h047});

        // Asynchronous reset mid-ADD
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'h00; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("partial before reset", sum[1:0], 2'b11);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {busy, done, co, sum}, 11'h000);
        tick();
        check("reset held outputs", {busy, done, co, sum}, 11'h000);
        @(negedge clk);
        rst_n = 1'b1;
        a_in = 8'h80; b_in = 8'h80; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("accept on first edge after reset", {busy, done}, 2'b10);
        repeat (4) tick();
        check("post reset result", {done, co, sum}, {1'b1, 9'h101});
        tick();

        // Exhaustive small configurations
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    ex1(a[1:0], b[1:0], c[0]);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    ex2(a[3:0], b[3:0], c[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter: BITS, default 2, width of the shared adder slice in bits.
REQ-002 Parameter: WORDS, default 4, number of BITS-wide words per operand; legal range 1..16.
REQ-003 The operand width W SHALL be BITS*WORDS.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin one addition; sampled on the rising clk edge.
REQ-007 abort  input  1  cancels an addition in progress.
REQ-008 a_in  input  W  operand A; sampled only on accepted start.
REQ-009 b_in  input  W  operand B; sampled only on accepted start.
REQ-010 ci  input  1  carry-in; sampled only on accepted start.
REQ-011 busy  output  1  high while words are being added.
REQ-012 done  output  1  one-cycle pulse when sum and co are complete.
REQ-013 sum  output  W  result register.
REQ-014 co  output  1  final carry-out register.

Function
REQ-015 The block SHALL contain exactly one BITS-wide combinational ripple-carry slice, time-shared across words; no W-wide adder.
REQ-016 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-017 IDLE with start=1 SHALL accept the request at that edge, with the following effects:
- capture a_in, b_in and ci into internal registers;
- clear sum to 0 and co to 0;
- set the word index to 0;
- enter ADD.
REQ-018 start in ADD or DONE SHALL be ignored, with no capture and no effect.
REQ-019 In ADD, each edge SHALL perform the following:
- write sum[idx*BITS +: BITS] = A_word(idx) + B_word(idx) + carry_reg (low BITS bits);
- load carry_reg with the slice carry-out;
- increment idx.
REQ-020 Word 0 SHALL use the captured ci as carry_reg.
REQ-021 On the ADD edge that processes idx = WORDS-1, the FSM SHALL perform the following:
- load co with that slice's carry-out;
- enter DONE.
REQ-022 DONE SHALL hold done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-023 Latency: for start accepted at edge E0, done SHALL be high for the cycle after edge E(WORDS), i.e. WORDS+1 edges after acceptance.
REQ-024 busy SHALL be 1 exactly while in ADD; done SHALL be 1 exactly while in DONE; busy and done SHALL never both be 1.
REQ-025 sum and co SHALL hold their final values from DONE until the next accepted start.
REQ-026 abort=1 in ADD SHALL perform the following at that edge:
- enter IDLE;
- clear sum, co and carry_reg to 0;
- produce no done pulse.
REQ-027 If abort and the final word edge coincide, abort SHALL win.
REQ-028 abort in IDLE or DONE SHALL be ignored.
REQ-029 idx SHALL be ceil(log2(WORDS+1)) bits wide and SHALL never exceed WORDS-1 while in ADD.
REQ-030 WORDS=1 SHALL give one ADD cycle; done SHALL be high 2 edges after acceptance.
REQ-031 Carry arithmetic SHALL be unsigned modulo 2^W, with the overflow reported only on co.

Reset
REQ-032 rst_n=0 SHALL, asynchronously and in any state, apply the following values:
- FSM to IDLE;
- busy=0, done=0;
- sum=0, co=0;
- idx=0, carry_reg=0;
- operand registers to 0.
REQ-033 Reset asserted mid-ADD SHALL discard the operation with no done pulse.
REQ-034 After rst_n deasserts, start SHALL be accepted on the first rising clk edge where rst_n=1.

Verification
REQ-035 BITS=2, WORDS=4: a_in=8'hFF, b_in=8'h01, ci=0, start pulse, with the following required response:
- busy high for 4 cycles;
- done on the 5th edge after acceptance;
- sum=8'h00, co=1.
REQ-036 a_in=8'h5A, b_in=8'h33, ci=1 -> sum=8'h8E, co=0.
REQ-037 Start held high continuously with different operands while busy -> the second value is ignored, sum reflects the first operands only, and a new accept occurs in the first IDLE cycle after DONE.
REQ-038 abort pulsed on the 2nd ADD cycle -> sum=0, co=0, no done pulse, IDLE next cycle; a following start completes normally.
REQ-039 rst_n pulsed low asynchronously (between edges) during ADD -> all outputs 0 immediately, no done pulse.
REQ-040 Exhaustive run for BITS=2, WORDS=1 and BITS=2, WORDS=2 over all a_in, b_in and ci -> {co,sum} equals a_in+b_in+ci for every case.
